// File: rtl/prol16_mem_pkg.sv
// Shared types and default widths for the PROL16 memory controller.
package prol16_mem_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int WAIT_STATES_DEF = 1;
  localparam int CNT_WIDTH       = 4;
  localparam int STAT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_HALT
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/prol16_mem_array.sv
// Single-clock word array: load port and CPU write port (load wins on
// the same word), one registered read port whose register clears on reset.
module prol16_mem_array #(
  parameter int gDataWidth = 16,
  parameter int gAddrWidth = 8
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  ld_we,
  input  logic [gAddrWidth-1:0] ld_addr,
  input  logic [gDataWidth-1:0] ld_data,
  input  logic                  cpu_we,
  input  logic [gAddrWidth-1:0] cpu_addr,
  input  logic [gDataWidth-1:0] cpu_data,
  input  logic                  rd_en,
  input  logic [gAddrWidth-1:0] rd_addr,
  output logic [gDataWidth-1:0] rd_data
);

  localparam int DEPTH = 1 << gAddrWidth;

  logic [gDataWidth-1:0] mem_reg [DEPTH];
  logic [gDataWidth-1:0] rd_data_reg;

  // Contents are deliberately untouched by reset; the later load write wins.
  always_ff @(posedge clk) begin
    if (cpu_we) mem_reg[cpu_addr] <= cpu_data;
    if (ld_we)  mem_reg[ld_addr]  <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/prol16_mem_ctrl.sv
// PROL16 memory controller: strobe handshake with wait states, halt and error flags.
// Define PROL16_MEM_STATS_EN to build the saturating read/write access counters.
module prol16_mem_ctrl
  import prol16_mem_pkg::*;
#(
  parameter int gDataWidth  = DATA_WIDTH_DEF,
  parameter int gAddrWidth  = ADDR_WIDTH_DEF,
  parameter int gWaitStates = WAIT_STATES_DEF
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  input  logic [gDataWidth-1:0] mem_addr_i,
  input  logic [gDataWidth-1:0] mem_data_i,
  output logic [gDataWidth-1:0] mem_data_o,
  input  logic                  mem_ce_n_i,
  input  logic                  mem_oe_n_i,
  input  logic                  mem_we_n_i,
  output logic                  mem_ready_o,
  input  logic                  illegal_inst_i,
  input  logic                  cpu_halt_i,
  input  logic                  load_en_i,
  input  logic [gAddrWidth-1:0] load_addr_i,
  input  logic [gDataWidth-1:0] load_data_i,
  output logic                  halted_o,
  output logic                  illegal_o,
  output logic                  err_o,
  output logic [STAT_WIDTH-1:0] rd_cnt_o,
  output logic [STAT_WIDTH-1:0] wr_cnt_o
);

  state_t                state_reg;
  op_t                   op_reg;
  logic [gAddrWidth-1:0] addr_reg;
  logic [gDataWidth-1:0] data_reg;
  logic                  bad_addr_reg;
  logic                  rd_zero_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic                  ready_reg;
  logic                  halted_reg;
  logic                  illegal_reg;
  logic                  err_reg;

  logic                  strobe_rd;
  logic                  strobe_wr;
  logic                  req_ok;
  logic                  req_conflict;
  logic                  req_bad;
  logic                  enter_from_idle;
  logic                  enter_from_wait;
  logic                  rd_en;
  logic                  rd_zero_next;
  logic                  cpu_we;
  logic [gAddrWidth-1:0] rd_addr;
  logic [gDataWidth-1:0] rd_data;

  assign strobe_rd    = !mem_ce_n_i && !mem_oe_n_i;
  assign strobe_wr    = !mem_ce_n_i && !mem_we_n_i;
  assign req_ok       = strobe_rd ^ strobe_wr;
  assign req_conflict = strobe_rd && strobe_wr;
  assign req_bad      = |mem_addr_i[gDataWidth-1:gAddrWidth];

  assign enter_from_idle = (state_reg == ST_IDLE) && req_ok && (gWaitStates == 0);
  assign enter_from_wait = (state_reg == ST_WAIT) && (cnt_reg == CNT_WIDTH'(1));

  // The array's read register doubles as the data-out holding register,
  // so the read is launched on the same edge that enters ACCESS.
  assign rd_en = !res_i && !cpu_halt_i &&
                 ((enter_from_idle && strobe_rd) || (enter_from_wait && op_reg == OP_RD));
  assign rd_addr      = (state_reg == ST_IDLE) ? mem_addr_i[gAddrWidth-1:0] : addr_reg;
  assign rd_zero_next = (state_reg == ST_IDLE) ? req_bad : bad_addr_reg;

  assign cpu_we = (state_reg == ST_ACCESS) && (op_reg == OP_WR) && !bad_addr_reg &&
                  !cpu_halt_i && !res_i;

  always_ff @(posedge clk_i) begin
    if (state_reg == ST_IDLE && req_ok) begin
      op_reg       <= strobe_wr ? OP_WR : OP_RD;
      addr_reg     <= mem_addr_i[gAddrWidth-1:0];
      data_reg     <= mem_data_i;
      bad_addr_reg <= req_bad;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      ready_reg   <= 1'b0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      err_reg     <= 1'b0;
      rd_zero_reg <= 1'b0;
    end else begin
      if (illegal_inst_i) illegal_reg <= 1'b1;
      if (rd_en)          rd_zero_reg <= rd_zero_next;
      if (cpu_halt_i) begin
        state_reg  <= ST_HALT;
        ready_reg  <= 1'b0;
        halted_reg <= 1'b1;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            if (req_conflict) begin
              err_reg <= 1'b1;
            end else if (req_ok) begin
              if (req_bad) err_reg <= 1'b1;
              if (gWaitStates == 0) begin
                state_reg <= ST_ACCESS;
                ready_reg <= 1'b1;
              end else begin
                state_reg <= ST_WAIT;
                cnt_reg   <= CNT_WIDTH'(gWaitStates);
              end
            end
          end
          ST_WAIT: begin
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_WIDTH'(1)) begin
              state_reg <= ST_ACCESS;
              ready_reg <= 1'b1;
            end
          end
          ST_ACCESS: begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
          end
          default: begin
            state_reg <= ST_HALT;
          end
        endcase
      end
    end
  end

  prol16_mem_array #(
    .gDataWidth(gDataWidth),
    .gAddrWidth(gAddrWidth)
  ) u_array (
    .clk     (clk_i),
    .srst    (res_i),
    .ld_we   (load_en_i),
    .ld_addr (load_addr_i),
    .ld_data (load_data_i),
    .cpu_we  (cpu_we),
    .cpu_addr(addr_reg),
    .cpu_data(data_reg),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign mem_data_o  = rd_zero_reg ? '0 : rd_data;
  assign mem_ready_o = ready_reg;
  assign halted_o    = halted_reg;
  assign illegal_o   = illegal_reg;
  assign err_o       = err_reg;

`ifdef PROL16_MEM_STATS_EN
  logic [STAT_WIDTH-1:0] rd_cnt_reg;
  logic [STAT_WIDTH-1:0] wr_cnt_reg;
  logic                  access_done;

  // Out-of-range accesses still complete the handshake, so they count.
  assign access_done = (state_reg == ST_ACCESS) && !cpu_halt_i;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else if (access_done) begin
      if (op_reg == OP_RD) rd_cnt_reg <= sat_inc(rd_cnt_reg);
      else                 wr_cnt_reg <= sat_inc(wr_cnt_reg);
    end
  end

  assign rd_cnt_o = rd_cnt_reg;
  assign wr_cnt_o = wr_cnt_reg;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule
